// File: rtl/inst_queue_pkg.sv
// Shared constants and entry layout for the fetch-to-decode instruction queue.
package inst_queue_pkg;

  localparam int IQ_DEPTH = 8;
  localparam int EXCODE_W = 5;

  localparam logic [EXCODE_W-1:0] EXC_ADEL = 5'h04;
  localparam logic [EXCODE_W-1:0] EXC_IBE  = 5'h06;

  typedef struct packed {
    logic [31:0]         pc;
    logic [31:0]         inst;
    logic                ex;
    logic [EXCODE_W-1:0] excode;
  } iq_entry_t;

endpackage

// File: rtl/inst_queue.sv
// Instruction queue between fetch and pre-decode; tracks MIPS delay-slot
// ownership of the head entry and handles flush and taken-branch redirect.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter  int DEPTH = IQ_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                push_valid,
  output logic                push_ready,
  input  logic [31:0]         push_pc,
  input  logic [31:0]         push_inst,
  input  logic                push_ex,
  input  logic [EXCODE_W-1:0] push_excode,
  output logic                pop_valid,
  input  logic                pop_ready,
  output logic [31:0]         pop_pc,
  output logic [31:0]         pop_inst,
  output logic                pop_ex,
  output logic [EXCODE_W-1:0] pop_excode,
  output logic                pop_ds,
  input  logic                pd_branch,
  input  logic                flush,
  input  logic                redirect,
  output logic                ds_missing,
  output logic [PTR_W:0]      count
);

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

  iq_entry_t        mem [DEPTH];
  iq_entry_t        head;
  iq_entry_t        wr_entry;
  logic [PTR_W-1:0] rptr, wptr;
  logic [PTR_W-1:0] rptr_n, wptr_n;
  logic [PTR_W:0]   count_n;
  logic             ds_flag, ds_flag_n;
  logic             ds_missing_n;
  logic             wr_en;
  logic             push_fire, pop_fire;

  assign push_ready = (count != CNT_FULL);
  assign pop_valid  = (count != '0);
  assign push_fire  = push_valid & push_ready;
  assign pop_fire   = pop_valid & pop_ready;

  assign head       = mem[rptr];
  assign pop_pc     = head.pc;
  assign pop_inst   = head.inst;
  assign pop_ex     = head.ex;
  assign pop_excode = head.excode;
  assign pop_ds     = ds_flag;

  assign wr_entry = '{pc: push_pc, inst: push_inst, ex: push_ex, excode: push_excode};

  always_comb begin
    rptr_n       = rptr;
    wptr_n       = wptr;
    count_n      = count;
    ds_flag_n    = ds_flag;
    ds_missing_n = 1'b0;
    wr_en        = 1'b0;

    if (flush) begin
      rptr_n    = '0;
      wptr_n    = '0;
      count_n   = '0;
      ds_flag_n = 1'b0;
    end else if (redirect) begin
      // Incoming fetches belong to the wrong path; only the delay slot survives.
      if (ds_flag) begin
        if (pop_fire) begin
          rptr_n    = rptr + 1'b1;
          wptr_n    = rptr + 1'b1;
          count_n   = '0;
          ds_flag_n = pd_branch;
        end else if (count != '0) begin
          wptr_n  = rptr + 1'b1;
          count_n = (PTR_W + 1)'(1);
        end else begin
          // Delay slot not fetched yet: the next push will be it.
          ds_missing_n = 1'b1;
        end
      end else begin
        rptr_n    = '0;
        wptr_n    = '0;
        count_n   = '0;
        ds_flag_n = pop_fire ? pd_branch : 1'b0;
      end
    end else begin
      if (push_fire) begin
        wr_en  = 1'b1;
        wptr_n = wptr + 1'b1;
      end
      if (pop_fire) begin
        rptr_n    = rptr + 1'b1;
        ds_flag_n = pd_branch;
      end
      case ({push_fire, pop_fire})
        2'b10:   count_n = count + 1'b1;
        2'b01:   count_n = count - 1'b1;
        default: count_n = count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rptr       <= '0;
      wptr       <= '0;
      count      <= '0;
      ds_flag    <= 1'b0;
      ds_missing <= 1'b0;
    end else begin
      rptr       <= rptr_n;
      wptr       <= wptr_n;
      count      <= count_n;
      ds_flag    <= ds_flag_n;
      ds_missing <= ds_missing_n;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wptr] <= wr_entry;
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: ordering, full, delay-slot tracking,
// redirect, flush and asynchronous reset.
module tb_inst_queue;
  import inst_queue_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        push_valid, push_ready;
  logic [31:0] push_pc, push_inst;
  logic        push_ex;
  logic [4:0]  push_excode;
  logic        pop_valid, pop_ready;
  logic [31:0] pop_pc, pop_inst;
  logic        pop_ex;
  logic [4:0]  pop_excode;
  logic        pop_ds, pd_branch, flush, redirect, ds_missing;
  logic [3:0]  count;

  int errors = 0;
  int checks = 0;

  inst_queue #(.DEPTH(8)) dut (
    .clk(clk), .resetn(resetn),
    .push_valid(push_valid), .push_ready(push_ready),
    .push_pc(push_pc), .push_inst(push_inst),
    .push_ex(push_ex), .push_excode(push_excode),
    .pop_valid(pop_valid), .pop_ready(pop_ready),
    .pop_pc(pop_pc), .pop_inst(pop_inst),
    .pop_ex(pop_ex), .pop_excode(pop_excode),
    .pop_ds(pop_ds), .pd_branch(pd_branch),
    .flush(flush), .redirect(redirect),
    .ds_missing(ds_missing), .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] pc, input logic [31:0] inst);
    push_valid = 1'b1;
    push_pc    = pc;
    push_inst  = inst;
    tick();
    push_valid = 1'b0;
  endtask

  task automatic pop_one(input logic br);
    pop_ready = 1'b1;
    pd_branch = br;
    tick();
    pop_ready = 1'b0;
    pd_branch = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0; push_valid = 1'b0; push_pc = '0; push_inst = '0;
    push_ex = 1'b0; push_excode = '0; pop_ready = 1'b0; pd_branch = 1'b0;
    flush = 1'b0; redirect = 1'b0;
    tick(); tick();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL reset_pop_valid: got %b want 0", pop_valid); end
    checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL reset_push_ready: got %b want 1", push_ready); end
    checks++; if (pop_ds !== 1'b0 || ds_missing !== 1'b0) begin errors++; $display("FAIL reset_ds: got ds=%b miss=%b want 0 0", pop_ds, ds_missing); end
    checks++; if (pop_pc !== 32'h0 || pop_inst !== 32'h0) begin errors++; $display("FAIL reset_pop_data: got pc=%h inst=%h want 0 0", pop_pc, pop_inst); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_order;
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hBFC00000; exp_pc[1] = 32'hBFC00004; exp_pc[2] = 32'hBFC00008;
    push_one(exp_pc[0], 32'h24080001);
    push_one(exp_pc[1], 32'h24090002);
    push_ex = 1'b1; push_excode = EXC_ADEL;
    push_one(exp_pc[2], 32'h240A0003);
    push_ex = 1'b0; push_excode = '0;
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL order_count: got %0d want 3", count); end
    checks++; if (pop_pc !== 32'hBFC00000) begin errors++; $display("FAIL order_head: got %h want bfc00000", pop_pc); end
    pop_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (pop_valid !== 1'b1 || pop_pc !== exp_pc[i] || pop_inst !== (32'h24080001 + 32'h00010001 * i)) begin
        errors++; $display("FAIL order_pop%0d: got v=%b pc=%h inst=%h want v=1 pc=%h", i, pop_valid, pop_pc, pop_inst, exp_pc[i]);
      end
      if (i == 2) begin
        checks++;
        if (pop_ex !== 1'b1 || pop_excode !== 5'h04) begin errors++; $display("FAIL order_ex: got ex=%b code=%h want 1 04", pop_ex, pop_excode); end
      end
      tick();
    end
    pop_ready = 1'b0;
    checks++; if (pop_valid !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL order_empty: got v=%b count=%0d want 0 0", pop_valid, count); end
  endtask

  task automatic test_full;
    for (int i = 0; i < 8; i++) push_one(32'h00001000 + 32'(4 * i), 32'h0);
    checks++; if (count !== 4'd8 || push_ready !== 1'b0) begin errors++; $display("FAIL full_state: got count=%0d ready=%b want 8 0", count, push_ready); end
    push_valid = 1'b1; push_pc = 32'h0000DEAD; pop_ready = 1'b1;
    tick();
    push_valid = 1'b0; pop_ready = 1'b0;
    checks++; if (count !== 4'd7 || push_ready !== 1'b1) begin errors++; $display("FAIL full_pushpop: got count=%0d ready=%b want 7 1", count, push_ready); end
    pop_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      checks++;
      if (pop_pc !== 32'h00001000 + 32'(4 * i)) begin errors++; $display("FAIL full_drain%0d: got %h want %h", i, pop_pc, 32'h00001000 + 32'(4 * i)); end
      tick();
    end
    pop_ready = 1'b0;
    checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL full_dropped: got pop_valid=%b want 0", pop_valid); end
  endtask

  task automatic test_ds;
    push_one(32'h00000100, 32'h10000003);
    push_one(32'h00000104, 32'h00000000);
    push_one(32'h00000108, 32'h24010001);
    pop_one(1'b1);
    checks++; if (pop_ds !== 1'b1 || pop_pc !== 32'h00000104) begin errors++; $display("FAIL ds_set: got ds=%b pc=%h want 1 00000104", pop_ds, pop_pc); end
    pop_one(1'b0);
    checks++; if (pop_ds !== 1'b0 || pop_pc !== 32'h00000108) begin errors++; $display("FAIL ds_clear: got ds=%b pc=%h want 0 00000108", pop_ds, pop_pc); end
    pop_one(1'b0);
  endtask

  task automatic test_redirect_keep;
    push_one(32'h00000200, 32'h10000003);
    push_one(32'h00000204, 32'h00000000);
    push_one(32'h00000208, 32'h24010001);
    push_one(32'h0000020C, 32'h24020002);
    pop_one(1'b1);
    checks++; if (count !== 4'd3 || pop_ds !== 1'b1) begin errors++; $display("FAIL rk_pre: got count=%0d ds=%b want 3 1", count, pop_ds); end
    redirect = 1'b1; push_valid = 1'b1; push_pc = 32'h0000BAD0;
    tick();
    redirect = 1'b0; push_valid = 1'b0;
    checks++; if (count !== 4'd1 || pop_pc !== 32'h00000204) begin errors++; $display("FAIL rk_keep: got count=%0d pc=%h want 1 00000204", count, pop_pc); end
    checks++; if (pop_ds !== 1'b1 || ds_missing !== 1'b0) begin errors++; $display("FAIL rk_ds: got ds=%b miss=%b want 1 0", pop_ds, ds_missing); end
    pop_one(1'b0);
    push_one(32'h00000300, 32'h24030003);
    checks++; if (count !== 4'd1 || pop_pc !== 32'h00000300 || pop_ds !== 1'b0) begin errors++; $display("FAIL rk_target: got count=%0d pc=%h ds=%b want 1 00000300 0", count, pop_pc, pop_ds); end
    pop_one(1'b0);
  endtask

  task automatic test_redirect_missing;
    push_one(32'h00000400, 32'h10000003);
    pop_one(1'b1);
    checks++; if (count !== 4'd0 || pop_ds !== 1'b1) begin errors++; $display("FAIL rm_pre: got count=%0d ds=%b want 0 1", count, pop_ds); end
    redirect = 1'b1;
    tick();
    redirect = 1'b0;
    checks++; if (ds_missing !== 1'b1 || count !== 4'd0 || pop_ds !== 1'b1) begin errors++; $display("FAIL rm_pulse: got miss=%b count=%0d ds=%b want 1 0 1", ds_missing, count, pop_ds); end
    tick();
    checks++; if (ds_missing !== 1'b0) begin errors++; $display("FAIL rm_pulse_end: got %b want 0", ds_missing); end
    push_one(32'h80000010, 32'h00000000);
    checks++; if (pop_valid !== 1'b1 || pop_pc !== 32'h80000010 || pop_ds !== 1'b1) begin errors++; $display("FAIL rm_slot: got v=%b pc=%h ds=%b want 1 80000010 1", pop_valid, pop_pc, pop_ds); end
    pop_one(1'b0);
    checks++; if (pop_ds !== 1'b0 || pop_valid !== 1'b0) begin errors++; $display("FAIL rm_after: got ds=%b v=%b want 0 0", pop_ds, pop_valid); end
  endtask

  task automatic test_flush_reset;
    for (int i = 0; i < 6; i++) push_one(32'h00000500 + 32'(4 * i), 32'h10000003);
    pop_one(1'b1);
    checks++; if (count !== 4'd5 || pop_ds !== 1'b1) begin errors++; $display("FAIL fl_pre: got count=%0d ds=%b want 5 1", count, pop_ds); end
    flush = 1'b1; push_valid = 1'b1; push_pc = 32'h0000BAD4;
    tick();
    flush = 1'b0; push_valid = 1'b0;
    checks++; if (count !== 4'd0 || pop_valid !== 1'b0 || pop_ds !== 1'b0 || ds_missing !== 1'b0) begin errors++; $display("FAIL fl_clear: got count=%0d v=%b ds=%b miss=%b want 0 0 0 0", count, pop_valid, pop_ds, ds_missing); end
    tick();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL fl_dropped: got count=%0d want 0", count); end
    push_one(32'h00000600, 32'h10000003);
    push_one(32'h00000604, 32'h00000000);
    pop_one(1'b1);
    #2 resetn = 1'b0;
    #1;
    checks++; if (count !== 4'd0 || pop_valid !== 1'b0 || push_ready !== 1'b1) begin errors++; $display("FAIL ar_ctrl: got count=%0d v=%b ready=%b want 0 0 1", count, pop_valid, push_ready); end
    checks++; if (pop_ds !== 1'b0 || ds_missing !== 1'b0 || pop_pc !== 32'h0) begin errors++; $display("FAIL ar_data: got ds=%b miss=%b pc=%h want 0 0 0", pop_ds, ds_missing, pop_pc); end
    tick();
    resetn = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_order();
    test_full();
    test_ds();
    test_redirect_keep();
    test_redirect_missing();
    test_flush_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
